// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if
// Load handshake between a value producer (e.g. the timekeeping core) and the
// display scan controller.
//   digits_in  : 4*NUM_DIG BCD digits, digit 0 least significant
//   dp_in      : NUM_DIG decimal point requests, 1 = lit
//   load       : producer strobe, honoured only while load_ready = 1
//   load_ready : controller has an empty pending buffer
// Modports: master = producer side, slave = scan controller side.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIG = 6
);
  logic [4*NUM_DIG-1:0] digits_in;
  logic [NUM_DIG-1:0]   dp_in;
  logic                 load;
  logic                 load_ready;

  modport master (
    output digits_in,
    output dp_in,
    output load,
    input  load_ready
  );

  modport slave (
    input  digits_in,
    input  dp_in,
    input  load,
    output load_ready
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed scan controller for a common-anode 7-segment display.
// One shared BCD-to-segment decoder is time-shared across NUM_DIG positions.
// Each digit slot lasts DIV cycles: BLANK all-off cycles (anti-ghosting,
// decoder settles on the new code) followed by DIV-BLANK cycles with the
// digit selected. New values arrive through a ready/load handshake into a
// pending buffer and are committed to the active buffer only at frame
// boundaries, so a frame never mixes old and new digits.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   en         : scan enable, 0 = display dark and scan restarted
//   ld         : load handshake (slave modport of seg_scan_ctrl_if)
//   num_out    : digit code to the shared decoder (10..15 passed through)
//   dp_n       : decimal point segment, active low
//   sel_n      : digit select, active low, at most one bit low
//   frame_tick : one-cycle pulse on the last cycle of each complete frame
module seg_scan_ctrl #(
  parameter int NUM_DIG = 6,
  parameter int DIV     = 5000,
  parameter int BLANK   = 50,
  parameter int LZB     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  seg_scan_ctrl_if.slave     ld,
  output logic [3:0]         num_out,
  output logic               dp_n,
  output logic [NUM_DIG-1:0] sel_n,
  output logic               frame_tick
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(NUM_DIG);
  localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] CNT_LAST       = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST       = IW'(NUM_DIG - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_SHOW
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [4*NUM_DIG-1:0] act_dig_q, act_dig_d;
  logic [NUM_DIG-1:0]   act_dp_q, act_dp_d;
  logic [4*NUM_DIG-1:0] pend_dig_q, pend_dig_d;
  logic [NUM_DIG-1:0]   pend_dp_q, pend_dp_d;
  logic                 pend_q, pend_d;
  logic                 load_ready_q, load_ready_d;
  logic [3:0]           num_out_q, num_out_d;
  logic                 dp_n_q, dp_n_d;
  logic [NUM_DIG-1:0]   sel_n_q, sel_n_d;
  logic                 frame_tick_q, frame_tick_d;

  logic                 capture;
  logic                 frame_end;
  logic [NUM_DIG-1:0]   lz_mask;
  logic                 zero_above;
  logic [3:0]           cur_num;
  logic                 cur_dp;
  logic                 cur_lz;

  // State register plus every registered output. Reset overrides en and load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      act_dig_q    <= '0;
      act_dp_q     <= '0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_q       <= 1'b0;
      load_ready_q <= 1'b1;
      num_out_q    <= 4'd0;
      dp_n_q       <= 1'b1;
      sel_n_q      <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_dig_q    <= act_dig_d;
      act_dp_q     <= act_dp_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_q       <= pend_d;
      load_ready_q <= load_ready_d;
      num_out_q    <= num_out_d;
      dp_n_q       <= dp_n_d;
      sel_n_q      <= sel_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Slot sequencing and the double buffer. frame_end marks the boundary at
  // which the pending value may become active: either entering the scan from
  // IDLE or leaving the final slot of a frame. Dropping en sends everything
  // back to IDLE but keeps the pending buffer for the next start.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    act_dig_d  = act_dig_q;
    act_dp_d   = act_dp_q;
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    pend_d     = pend_q;
    frame_end  = 1'b0;
    capture    = ld.load && load_ready_q;

    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_BLANK;
          cnt_d     = '0;
          idx_d     = '0;
          frame_end = 1'b1;
        end
        ST_BLANK: begin
          if (cnt_q == CNT_BLANK_LAST) begin
            state_d = ST_SHOW;
          end
          cnt_d = cnt_q + 1'b1;
        end
        ST_SHOW: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d     = '0;
              frame_end = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end

    // Capture and commit never coincide: capture needs an empty pending
    // buffer, commit needs a full one.
    if (frame_end && pend_q) begin
      act_dig_d = pend_dig_q;
      act_dp_d  = pend_dp_q;
      pend_d    = 1'b0;
    end
    if (capture) begin
      pend_dig_d = ld.digits_in;
      pend_dp_d  = ld.dp_in;
      pend_d     = 1'b1;
    end
    load_ready_d = !pend_d;
  end

  // Leading-zero mask: digit i>0 is suppressed when it and every more
  // significant digit of the value about to be active are zero.
  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIG - 1; i >= 1; i--) begin
      zero_above = zero_above && (act_dig_d[4*i +: 4] == 4'd0);
      lz_mask[i] = (LZB != 0) && zero_above;
    end
  end

  // Output decode from the next-cycle state so that the registered outputs
  // line up with the state they describe.
  always_comb begin
    cur_num      = 4'd0;
    cur_dp       = 1'b0;
    cur_lz       = 1'b0;
    num_out_d    = 4'd0;
    dp_n_d       = 1'b1;
    sel_n_d      = '1;
    frame_tick_d = 1'b0;

    for (int i = 0; i < NUM_DIG; i++) begin
      if (idx_d == IW'(i)) begin
        cur_num = act_dig_d[4*i +: 4];
        cur_dp  = act_dp_d[i];
        cur_lz  = lz_mask[i];
      end
    end

    case (state_d)
      ST_BLANK: begin
        num_out_d = cur_num;
      end
      ST_SHOW: begin
        num_out_d    = cur_num;
        frame_tick_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
        if (!cur_lz) begin
          dp_n_d = ~cur_dp;
          for (int i = 0; i < NUM_DIG; i++) begin
            if (idx_d == IW'(i)) begin
              sel_n_d[i] = 1'b0;
            end
          end
        end
      end
      default: begin
        num_out_d = 4'd0;
      end
    endcase
  end

  assign ld.load_ready = load_ready_q;
  assign num_out       = num_out_q;
  assign dp_n          = dp_n_q;
  assign sel_n         = sel_n_q;
  assign frame_tick    = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
// Scoreboard bench for seg_scan_ctrl with NUM_DIG=4, DIV=8, BLANK=2.
// Instance u0 has LZB=0, instance u1 has LZB=1. The stimulus process pushes
// one record per expected visible digit slot; the monitor pops a record each
// time a DUT starts selecting a digit and compares select, code, dp and the
// number of cycles the digit stays selected.
module tb_seg_scan_ctrl;

  typedef struct {
    int         inst;
    logic [3:0] sel;
    logic [3:0] num;
    logic       dpn;
    int         len;
  } slot_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en0, en1;
  logic [3:0] num_out0, num_out1;
  logic [3:0] sel_n0, sel_n1;
  logic       dp_n0, dp_n1;
  logic       frame_tick0, frame_tick1;

  int    n_assert = 0;
  int    n_fail   = 0;
  slot_t exp_q[$];

  int    cyc = 0;
  int    cur_len [2];
  bit    in_slot [2];
  bit    cur_valid [2];
  slot_t cur_exp [2];
  logic [3:0] slot_sel [2];
  int    ticks [2];
  bit    have_prev [2];
  int    last_tick [2];

  seg_scan_ctrl_if #(.NUM_DIG(4)) bus0 ();
  seg_scan_ctrl_if #(.NUM_DIG(4)) bus1 ();

  seg_scan_ctrl #(.NUM_DIG(4), .DIV(8), .BLANK(2), .LZB(0)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .en         (en0),
    .ld         (bus0),
    .num_out    (num_out0),
    .dp_n       (dp_n0),
    .sel_n      (sel_n0),
    .frame_tick (frame_tick0)
  );

  seg_scan_ctrl #(.NUM_DIG(4), .DIV(8), .BLANK(2), .LZB(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .en         (en1),
    .ld         (bus1),
    .num_out    (num_out1),
    .dp_n       (dp_n1),
    .sel_n      (sel_n1),
    .frame_tick (frame_tick1)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // One counted comparison; any difference is reported as a FAIL line.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    n_assert++;
    if (actual !== required) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // Drive the load side of one instance's handshake.
  task automatic applyStimulus(input int inst, input logic load,
                               input logic [15:0] digits, input logic [3:0] dp);
    if (inst == 0) begin
      bus0.load      = load;
      bus0.digits_in = digits;
      bus0.dp_in     = dp;
    end else begin
      bus1.load      = load;
      bus1.digits_in = digits;
      bus1.dp_in     = dp;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for the next frame_tick of one instance, bounded to 100 cycles.
  task automatic wait_tick(input int inst);
    int k;
    bit seen;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 100) begin
      @(negedge clk);
      k++;
      seen = (inst == 0) ? frame_tick0 : frame_tick1;
    end
    checkOutput($sformatf("u%0d_tick_timeout", inst), seen, 1);
  endtask

  task automatic expect_slot(input int inst, input logic [3:0] sel,
                             input logic [3:0] num, input logic dpn, input int len);
    slot_t s;
    s.inst = inst;
    s.sel  = sel;
    s.num  = num;
    s.dpn  = dpn;
    s.len  = len;
    exp_q.push_back(s);
  endtask

  // Full frame with every digit visible for 6 cycles; dpn is the expected
  // active-low dp pattern.
  task automatic push_frame(input int inst, input logic [15:0] d, input logic [3:0] dpn);
    logic [3:0] sel;
    logic [3:0] one;
    for (int k = 0; k < 4; k++) begin
      one = 4'b0001 << k;
      sel = ~one;
      expect_slot(inst, sel, d[4*k +: 4], dpn[k], 6);
    end
  endtask

  task automatic check_dark0(input string tag);
    checkOutput({tag, "_sel"},  sel_n0, 4'hF);
    checkOutput({tag, "_dp"},   dp_n0, 1);
    checkOutput({tag, "_num"},  num_out0, 0);
    checkOutput({tag, "_tick"}, frame_tick0, 0);
  endtask

  // Monitor: at every falling edge track visible slots of both instances,
  // pop and compare expectations, and check frame_tick placement and period.
  always @(negedge clk) begin : monitor
    logic [3:0] sel;
    logic [3:0] num;
    logic       dpn;
    logic       tk;
    logic       en_i;
    int         found;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      sel  = (i == 0) ? sel_n0 : sel_n1;
      num  = (i == 0) ? num_out0 : num_out1;
      dpn  = (i == 0) ? dp_n0 : dp_n1;
      tk   = (i == 0) ? frame_tick0 : frame_tick1;
      en_i = (i == 0) ? en0 : en1;

      checkOutput($sformatf("u%0d_sel_onehot", i), ($countones(~sel) <= 1), 1);
      if (sel == 4'hF) begin
        checkOutput($sformatf("u%0d_dark_dp", i), dpn, 1);
      end

      if (in_slot[i] && sel != slot_sel[i]) begin
        if (cur_valid[i]) begin
          checkOutput($sformatf("u%0d_slot_len", i), cur_len[i], cur_exp[i].len);
        end
        in_slot[i] = 1'b0;
      end

      if (!in_slot[i] && sel != 4'hF) begin
        found = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
          if (found < 0 && exp_q[k].inst == i) found = k;
        end
        in_slot[i]  = 1'b1;
        slot_sel[i] = sel;
        cur_len[i]  = 0;
        if (found < 0) begin
          cur_valid[i] = 1'b0;
          checkOutput($sformatf("u%0d_unexpected_slot", i), sel, 4'hF);
        end else begin
          cur_valid[i] = 1'b1;
          cur_exp[i]   = exp_q[found];
          exp_q.delete(found);
          checkOutput($sformatf("u%0d_slot_sel", i), sel, cur_exp[i].sel);
        end
      end

      if (in_slot[i]) begin
        cur_len[i]++;
        if (cur_valid[i]) begin
          checkOutput($sformatf("u%0d_slot_num", i), num, cur_exp[i].num);
          checkOutput($sformatf("u%0d_slot_dp", i), dpn, cur_exp[i].dpn);
        end
      end

      if (rst || !en_i) have_prev[i] = 1'b0;

      if (tk) begin
        ticks[i]++;
        if (i == 0) begin
          checkOutput("u0_tick_sel", sel, 4'b0111);
          checkOutput("u0_tick_len", cur_len[i], 6);
        end
        if (have_prev[i]) begin
          checkOutput($sformatf("u%0d_tick_period", i), cyc - last_tick[i], 32);
        end
        have_prev[i] = 1'b1;
        last_tick[i] = cyc;
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence.
  initial begin
    rst = 1'b1;
    en0 = 1'b0;
    en1 = 1'b0;
    applyStimulus(0, 1'b0, 16'h0000, 4'b0000);
    applyStimulus(1, 1'b0, 16'h0000, 4'b0000);
    wait_cycles(3);
    rst = 1'b0;

    // Reset state held with en low
    for (int c = 0; c < 20; c++) begin
      wait_cycles(1);
      check_dark0("rst_idle");
      checkOutput("rst_ready", bus0.load_ready, 1);
    end

    // Load 4321 with dp on digit 2, then enable
    applyStimulus(0, 1'b1, 16'h4321, 4'b0100);
    wait_cycles(1);
    applyStimulus(0, 1'b0, 16'h4321, 4'b0100);
    checkOutput("ready_drop", bus0.load_ready, 0);
    push_frame(0, 16'h4321, 4'b1011);
    push_frame(0, 16'h4321, 4'b1011);
    en0 = 1'b1;
    wait_tick(0);
    push_frame(0, 16'h4321, 4'b1011);
    wait_tick(0);

    // Mid-frame load of 9999 while digit 1 is shown
    wait_cycles(11);
    applyStimulus(0, 1'b1, 16'h9999, 4'b0000);
    wait_cycles(1);
    applyStimulus(0, 1'b0, 16'h9999, 4'b0000);
    checkOutput("mid_ready_drop", bus0.load_ready, 0);
    push_frame(0, 16'h9999, 4'b1111);

    // Load while not ready must be ignored
    wait_cycles(1);
    applyStimulus(0, 1'b1, 16'h5555, 4'b1111);
    wait_cycles(2);
    applyStimulus(0, 1'b0, 16'h5555, 4'b1111);
    wait_tick(0);
    checkOutput("ready_before_commit", bus0.load_ready, 0);

    // Load on the commit cycle is ignored too
    applyStimulus(0, 1'b1, 16'h5555, 4'b1111);
    wait_cycles(1);
    applyStimulus(0, 1'b0, 16'h5555, 4'b1111);
    checkOutput("ready_after_commit", bus0.load_ready, 1);
    checkOutput("new_frame_num", num_out0, 4'h9);
    checkOutput("new_frame_blank", sel_n0, 4'hF);
    wait_tick(0);
    checkOutput("commit_load_ignored", bus0.load_ready, 1);

    // Drop en during digit 2 SHOW (visible for 3 cycles)
    expect_slot(0, 4'b1110, 4'h9, 1'b1, 6);
    expect_slot(0, 4'b1101, 4'h9, 1'b1, 6);
    expect_slot(0, 4'b1011, 4'h9, 1'b1, 3);
    wait_cycles(21);
    en0 = 1'b0;
    wait_cycles(1);
    check_dark0("abort");
    applyStimulus(0, 1'b1, 16'hA765, 4'b0001);
    wait_cycles(1);
    applyStimulus(0, 1'b0, 16'hA765, 4'b0001);
    checkOutput("pend_held_idle", bus0.load_ready, 0);
    wait_cycles(10);
    check_dark0("idle_after_abort");
    checkOutput("no_abort_tick", ticks[0], 4);

    // Re-enable: pending A765 committed on entry, code 10 passes through
    push_frame(0, 16'hA765, 4'b1110);
    en0 = 1'b1;
    wait_cycles(1);
    checkOutput("commit_on_entry", bus0.load_ready, 1);
    checkOutput("entry_num", num_out0, 4'h5);
    checkOutput("entry_blank", sel_n0, 4'hF);
    wait_tick(0);

    // Reset during digit 1 SHOW with a pending value
    expect_slot(0, 4'b1110, 4'h5, 1'b0, 6);
    expect_slot(0, 4'b1101, 4'h6, 1'b1, 1);
    wait_cycles(10);
    applyStimulus(0, 1'b1, 16'h1111, 4'b0000);
    wait_cycles(1);
    applyStimulus(0, 1'b0, 16'h1111, 4'b0000);
    checkOutput("pre_rst_ready", bus0.load_ready, 0);
    rst = 1'b1;
    wait_cycles(1);
    check_dark0("mid_rst");
    checkOutput("rst_ready_back", bus0.load_ready, 1);
    rst = 1'b0;
    en0 = 1'b0;
    wait_cycles(3);
    checkOutput("u0_tick_count", ticks[0], 5);

    // Leading-zero blanking on u1: 0070 shows digits 0 and 1 only
    applyStimulus(1, 1'b1, 16'h0070, 4'b0000);
    wait_cycles(1);
    applyStimulus(1, 1'b0, 16'h0070, 4'b0000);
    checkOutput("u1_ready_drop", bus1.load_ready, 0);
    expect_slot(1, 4'b1110, 4'h0, 1'b1, 6);
    expect_slot(1, 4'b1101, 4'h7, 1'b1, 6);
    expect_slot(1, 4'b1110, 4'h0, 1'b1, 6);
    expect_slot(1, 4'b1101, 4'h7, 1'b1, 6);
    en1 = 1'b1;
    wait_tick(1);

    // 0000 with dp on digit 3: only digit 0 visible, dp does not exempt
    wait_cycles(1);
    applyStimulus(1, 1'b1, 16'h0000, 4'b1000);
    wait_cycles(1);
    applyStimulus(1, 1'b0, 16'h0000, 4'b1000);
    checkOutput("u1_mid_ready_drop", bus1.load_ready, 0);
    expect_slot(1, 4'b1110, 4'h0, 1'b1, 6);
    wait_tick(1);
    wait_cycles(11);
    checkOutput("u1_lzb_dig1_sel", sel_n1, 4'hF);
    wait_cycles(16);
    checkOutput("u1_lzb_dig3_sel", sel_n1, 4'hF);
    checkOutput("u1_lzb_dig3_num", num_out1, 4'h0);
    wait_tick(1);
    en1 = 1'b0;
    wait_cycles(2);
    checkOutput("u1_tick_count", ticks[1], 3);
    checkOutput("u1_dark_after", sel_n1, 4'hF);

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the watch's common-anode 7-segment display (HH:MM:SS).
- Sequences one shared BCD-to-segment decoder across NUM_DIG digit positions. Per slot it drives the digit code to the decoder, the decimal point and an active-low digit select.
- Inserts an all-off blanking interval before each digit to prevent ghosting.
- Accepts new display values through a ready/load handshake. The values are double-buffered and committed only at frame boundaries, so a frame never shows mixed old and new digits.

Parameters:
- NUM_DIG, 6, number of digit positions scanned (2..8).
- DIV, 5000, clk cycles per digit slot (blank plus show).
- BLANK, 50, all-off cycles at the start of each slot (1..DIV-1).
- LZB, 0, 1 = leading-zero blanking enabled.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: scan enable. 0 = display dark.
- digits_in, input, 4*NUM_DIG: BCD digits. Digit i = digits_in[4i+3:4i]. Digit 0 is least significant.
- dp_in, input, NUM_DIG: decimal point request per digit. 1 = lit.
- load, input, 1: capture digits_in/dp_in when load_ready=1.
- load_ready, output, 1: 1 = pending buffer empty.
- num_out, output, 4: digit code to the shared decoder.
- dp_n, output, 1: decimal point segment. Active low.
- sel_n, output, NUM_DIG: digit select. Active low, at most one bit low.
- frame_tick, output, 1: one-cycle pulse on the last cycle of each complete frame.

Behaviour:
- All outputs are registered.
- Reset values:
  - sel_n all 1, num_out 0, dp_n 1, frame_tick 0, load_ready 1.
  - Active and pending buffers 0, pending flag 0.
  - Slot counter 0, digit index 0, state IDLE.
- Handshake:
  - load=1 while load_ready=1 captures digits_in/dp_in into the pending buffer and sets the pending flag.
  - load_ready is registered as !pending. It drops the cycle after capture.
  - load=1 while load_ready=0 is ignored. Data is not stored and no error is raised.
- Commit (pending to active, then clear the pending flag) happens:
  - on the IDLE->BLANK transition, or
  - on the last cycle of the final slot of a frame.
  - load_ready returns to 1 the cycle after commit.
  - A load presented on the commit cycle is ignored, because load_ready is still 0.
- State IDLE:
  - sel_n all 1, dp_n 1, counters held at 0.
  - Next state is BLANK when en=1.
- State BLANK:
  - sel_n all 1, dp_n 1.
  - num_out = active digit[idx], so the decoder settles before select.
  - Slot counter runs 0..BLANK-1, then the state moves to SHOW.
- State SHOW:
  - sel_n[idx]=0, num_out = active digit[idx], dp_n = ~active dp[idx].
  - Slot counter runs BLANK..DIV-1.
  - At DIV-1, the counter goes to 0, idx goes to idx+1 (wrapping NUM_DIG-1 to 0) and the state goes to BLANK.
  - frame_tick=1 on the DIV-1 cycle of idx NUM_DIG-1.
- Frame length is exactly NUM_DIG*DIV cycles. Each digit is selected for DIV-BLANK cycles.
- en falling at any point:
  - The next cycle is IDLE with all outputs dark, counters and idx at 0.
  - No frame_tick is generated for the aborted frame.
  - The pending buffer is retained.
- Leading-zero blanking (LZB=1):
  - Applies to digit i>0 whose active value is 0 and all of whose more significant digits are 0.
  - Such a digit keeps sel_n all 1 during its SHOW. Slot timing is unchanged.
  - Digit 0 is never blanked.
  - dp_in does not exempt a digit from LZB.
- Codes 10..15 are passed through unchanged. The decoder renders them as 'F'.
- Synchronous rst overrides en and load on the same cycle.
- Reset mid-frame blanks the display on the next cycle.

Test Plan:
Bench parameters for all scenarios: NUM_DIG=4, DIV=8, BLANK=2, LZB=0 unless stated.
1. Reset with en=0 -> sel_n=4'b1111, dp_n=1, load_ready=1, frame_tick=0 for 20 cycles.
2. Load digits_in=16'h4321, dp_in=4'b0100, then en=1:
   - Digit sequence is 1,2,3,4, each shows 2 blank cycles then 6 cycles of sel_n low on the matching bit.
   - dp_n=0 only while digit 2 is shown.
   - frame_tick pulses every 32 cycles.
3. Mid-frame load of 16'h9999 during digit 1:
   - load_ready drops next cycle.
   - The remainder of the frame still shows 4321.
   - From the next frame 9999 is shown, and load_ready=1 one cycle after the frame_tick cycle.
4. Second load while load_ready=0 (value 16'h5555) -> ignored. Display never shows 5.
5. LZB=1, load 16'h0070:
   - Digits 3 and 2 keep sel_n=1111 during their SHOW.
   - Digit 1 shows 7 and digit 0 shows 0.
   - Value 16'h0000 shows digit 0 only.
6. Drop en during digit 2 SHOW:
   - Next cycle all dark with no frame_tick.
   - Re-enable -> restarts at digit 0 BLANK, and any pending value is committed on entry.
   - Assert rst mid-SHOW -> dark next cycle and load_ready=1.
